halt_detector: RTL and testbench
================================

// Module: halt_detector
// PURPOSE
//   Sits upstream of the simulation cycle counter. Watches the CPU retire
//   stream and register-file write port, and decides when the program has
//   ended. Produces the isHalt level and the 16-bit return value the counter
//   reports. A program ends on an explicit halt instruction, or on a
//   self-loop: the same PC retiring repeatedly.
// PARAMETERS
//   HALT_MASK   16'hFFFF  mask applied to retire_instr before the halt compare
//   HALT_MATCH  16'hFFFF  halt when (retire_instr & HALT_MASK) == HALT_MATCH
//   RET_REG     3         register index mirrored into ret_val (0..7)
//   DRAIN_CYCLES 2        cycles between halt retire and isHalt, so in-flight writes land (0..15)
//   LOOP_LIMIT  8         consecutive same-PC retires that count as a halt; 0 disables
// PORTS
//   clk           in   1   system clock, all state on posedge
//   rst_n         in   1   asynchronous, active-low reset
//   retire_valid  in   1   an instruction retires this cycle
//   retire_pc     in   16  PC of the retiring instruction
//   retire_instr  in   16  encoding of the retiring instruction
//   rf_we         in   1   register-file write enable
//   rf_waddr      in   3   register-file write index
//   rf_wdata      in   16  register-file write data
//   isHalt        out  1   program finished; registered, sticky until reset
//   ret_val       out  16  shadow copy of register RET_REG
//   halt_pc       out  16  PC that caused the halt
//   halt_cause    out  2   0 = none, 1 = halt instruction, 2 = self-loop
//   instret       out  32  retired-instruction count, frozen once halting starts
// BEHAVIOUR
//   Reset values: all outputs 0. State is RUN. last_pc_vld = 0. Repeat count = 0.
//   States:
//     RUN    -> DRAIN or HALTED on a halt event
//     DRAIN  -> HALTED when drain_cnt reaches 0
//     HALTED -> stays until rst_n is asserted
//   Halt event: sampled only in RUN with retire_valid = 1.
//     instr: (retire_instr & HALT_MASK) == HALT_MATCH
//     loop:  LOOP_LIMIT != 0, and this retire is the LOOP_LIMIT-th consecutive
//            retire at the same PC
//     If both fire in one cycle, cause = 1 (instr wins).
//     On the event edge:
//       latch halt_pc = retire_pc and latch halt_cause
//       if DRAIN_CYCLES == 0, go to HALTED; otherwise go to DRAIN with
//       drain_cnt = DRAIN_CYCLES - 1
//   DRAIN: each edge, go to HALTED if drain_cnt == 0, otherwise decrement it.
//     isHalt is therefore high after edge T + DRAIN_CYCLES, where T is the
//     edge that sampled the halt retire.
//   Entering HALTED sets isHalt = 1. isHalt stays high until reset.
//   instret:
//     +1 per retire_valid in RUN, including the halting retire
//     not incremented in DRAIN or HALTED
//     wraps modulo 2^32
//   ret_val:
//     on rf_we with rf_waddr == RET_REG, in RUN or DRAIN, takes rf_wdata on the
//     next edge; a write in the same cycle as the halt retire is captured
//     frozen in HALTED; later writes are ignored
//   Loop tracking (RUN only), on each retire:
//     if last_pc_vld and retire_pc == last_pc: rep_cnt += 1
//     otherwise: rep_cnt = 1, last_pc = retire_pc, last_pc_vld = 1
//     rep_cnt is 16 bits and saturates at 16'hFFFF
//     cycles with retire_valid = 0 do not break a run of same-PC retires
//   Retires in DRAIN or HALTED: ignored entirely (no count, no new halt,
//     halt_pc and halt_cause unchanged).
//   Reset mid-DRAIN or mid-HALTED: returns to RUN with all outputs 0 immediately,
//     asynchronously.
// TESTING
//   1. RET_REG = 3: write r3 = 16'h002A, then retire 16'hFFFF at pc 16'h0040.
//      Expect isHalt after exactly 2 more edges, ret_val = 16'h002A,
//      halt_pc = 16'h0040, cause = 1.
//   2. r3 write of 16'h0007 in the halt-retire cycle, and another r3 write of
//      16'h0009 one cycle later (DRAIN). Expect ret_val = 16'h0009. A write
//      after isHalt leaves ret_val at 16'h0009.
//   3. Retire pc 16'h0010 eight times, with idle gaps between retires.
//      Expect cause = 2 and halt_pc = 16'h0010. Seven retires then pc 16'h0012:
//      no halt.
//   4. Halt instruction retiring as the 8th same-PC retire -> cause = 1.
//      With LOOP_LIMIT = 0, 100 same-PC retires -> isHalt stays 0.
//   5. 5 retires followed by a halt retire: instret = 6. Retires during
//      DRAIN/HALTED: instret stays at 6.
//   6. Assert rst_n low during DRAIN. Expect all outputs 0 without a clock
//      edge, and a fresh halt sequence works after release.

Source files
------------

// File: rtl/halt_detector_if.sv
// halt_detector_if: retire stream, register-file write port and halt status
// bundle for halt_detector.
//   master : retire_valid/pc/instr, rf_we/waddr/wdata out; status in
//   slave  : the reverse (used by halt_detector)
interface halt_detector_if;
   logic        retire_valid;
   logic [15:0] retire_pc;
   logic [15:0] retire_instr;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        isHalt;
   logic [15:0] ret_val;
   logic [15:0] halt_pc;
   logic [1:0]  halt_cause;
   logic [31:0] instret;

   modport master (
      output retire_valid, retire_pc, retire_instr, rf_we, rf_waddr, rf_wdata,
      input  isHalt, ret_val, halt_pc, halt_cause, instret
   );
   modport slave (
      input  retire_valid, retire_pc, retire_instr, rf_we, rf_waddr, rf_wdata,
      output isHalt, ret_val, halt_pc, halt_cause, instret
   );
endinterface

// File: rtl/halt_detector.sv
// halt_detector: decides when the simulated program has ended.
// A program ends on a halt instruction ((instr & HALT_MASK) == HALT_MATCH)
// or when the same PC retires LOOP_LIMIT times in a row. After the halting
// retire, DRAIN_CYCLES edges pass before isHalt rises so in-flight
// register writes still reach the ret_val shadow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : halt_detector_if.slave (retire stream, rf write port,
//                isHalt / ret_val / halt_pc / halt_cause / instret)
module halt_detector #(
   parameter logic [15:0] HALT_MASK    = 16'hFFFF,
   parameter logic [15:0] HALT_MATCH   = 16'hFFFF,
   parameter int          RET_REG      = 3,
   parameter int          DRAIN_CYCLES = 2,
   parameter int          LOOP_LIMIT   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   halt_detector_if.slave bus
);
   localparam logic [2:0]  RET_IDX   = RET_REG[2:0];
   localparam logic [15:0] LOOP_LIM  = LOOP_LIMIT[15:0];
   localparam int          DRAIN_M1  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
   localparam logic [3:0]  DRAIN_INI = DRAIN_M1[3:0];

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [3:0]  drain_cnt, drain_cnt_nxt;

   logic [15:0] last_pc;
   logic        last_pc_vld;
   logic [15:0] rep_cnt;
   logic [15:0] ret_val_q;
   logic [15:0] halt_pc_q;
   logic [1:0]  cause_q;
   logic [31:0] instret_q;

   logic        run_retire, instr_hit, same_pc, loop_hit, halt_evt;
   logic [15:0] rep_nxt;

   // Halt event decode; only meaningful for a retire while running.
   always_comb begin
      run_retire = (state == RUN) && bus.retire_valid;
      instr_hit  = (bus.retire_instr & HALT_MASK) == HALT_MATCH;
      same_pc    = last_pc_vld && (bus.retire_pc == last_pc);
      if (!same_pc)                rep_nxt = 16'd1;
      else if (rep_cnt == 16'hFFFF) rep_nxt = rep_cnt;
      else                          rep_nxt = rep_cnt + 16'd1;
      loop_hit   = (LOOP_LIMIT != 0) && (rep_nxt == LOOP_LIM);
      halt_evt   = run_retire && (instr_hit || loop_hit);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      case (state)
         RUN: if (halt_evt) begin
            if (DRAIN_CYCLES == 0) state_nxt = HALTED;
            else begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_INI;
            end
         end
         DRAIN: begin
            if (drain_cnt == 4'd0) state_nxt = HALTED;
            else                   drain_cnt_nxt = drain_cnt - 4'd1;
         end
         default: state_nxt = HALTED;
      endcase
   end

   // Datapath: loop tracking, counters, halt record, return-value shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pc     <= 16'd0;
         last_pc_vld <= 1'b0;
         rep_cnt     <= 16'd0;
         ret_val_q   <= 16'd0;
         halt_pc_q   <= 16'd0;
         cause_q     <= 2'd0;
         instret_q   <= 32'd0;
      end else begin
         if (run_retire) begin
            instret_q   <= instret_q + 32'd1;
            rep_cnt     <= rep_nxt;
            last_pc     <= bus.retire_pc;
            last_pc_vld <= 1'b1;
         end
         if (halt_evt) begin
            halt_pc_q <= bus.retire_pc;
            cause_q   <= instr_hit ? 2'd1 : 2'd2;
         end
         // Writes still land during DRAIN; the shadow freezes once halted.
         if (state != HALTED && bus.rf_we && bus.rf_waddr == RET_IDX)
            ret_val_q <= bus.rf_wdata;
      end
   end

   // Outputs (all decoded straight from flops)
   always_comb begin
      bus.isHalt     = (state == HALTED);
      bus.ret_val    = ret_val_q;
      bus.halt_pc    = halt_pc_q;
      bus.halt_cause = cause_q;
      bus.instret    = instret_q;
   end
endmodule

// File: tb/tb_halt_detector.sv
module tb_halt_detector;
   localparam logic [15:0] MASK  = 16'hFFFF;
   localparam logic [15:0] MATCH = 16'hFFFF;
   localparam int          RET   = 3;
   localparam int          DRAIN = 2;
   localparam int          LIMIT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   halt_detector_if b ();
   halt_detector_if b2 ();

   halt_detector #(.HALT_MASK(MASK), .HALT_MATCH(MATCH), .RET_REG(RET),
                   .DRAIN_CYCLES(DRAIN), .LOOP_LIMIT(LIMIT))
      dut (.clk(clk), .rst_n(rst_n), .bus(b));

   // Same stimulus, self-loop detection disabled.
   halt_detector #(.HALT_MASK(MASK), .HALT_MATCH(MATCH), .RET_REG(RET),
                   .DRAIN_CYCLES(DRAIN), .LOOP_LIMIT(0))
      dut_nl (.clk(clk), .rst_n(rst_n), .bus(b2));

   assign b2.retire_valid = b.retire_valid;
   assign b2.retire_pc    = b.retire_pc;
   assign b2.retire_instr = b.retire_instr;
   assign b2.rf_we        = b.rf_we;
   assign b2.rf_waddr     = b.rf_waddr;
   assign b2.rf_wdata     = b.rf_wdata;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: time-based view of the program end.
   int          m_cyc;
   int          m_halt_edge;
   bit          m_halting;
   logic [1:0]  m_cause;
   logic [15:0] m_pc;
   logic [15:0] m_ret;
   logic [31:0] m_instret;
   logic [15:0] hist[$];

   function automatic bit m_is_halt();
      return m_halting && (m_cyc >= m_halt_edge + DRAIN);
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_halt_edge = 0; m_halting = 0;
      m_cause = 2'd0; m_pc = 16'd0; m_ret = 16'd0; m_instret = 32'd0;
      hist.delete();
   endtask

   task automatic model_update();
      int  run;
      bit  hi, hl;
      if (!m_is_halt() && b.rf_we && b.rf_waddr == 3'(RET)) m_ret = b.rf_wdata;
      m_cyc++;
      if (!m_halting && b.retire_valid) begin
         m_instret++;
         hist.push_back(b.retire_pc);
         run = 0;
         for (int i = hist.size() - 1; i >= 0 && hist[i] == b.retire_pc; i--) run++;
         hi = (b.retire_instr & MASK) == MATCH;
         hl = (LIMIT != 0) && (run == LIMIT);
         if (hi || hl) begin
            m_halting = 1; m_halt_edge = m_cyc;
            m_cause = hi ? 2'd1 : 2'd2; m_pc = b.retire_pc;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      b.retire_valid = 0; b.retire_pc = 0; b.retire_instr = 0;
      b.rf_we = 0; b.rf_waddr = 0; b.rf_wdata = 0;
   endtask

   task automatic retire(input logic [15:0] pc, input logic [15:0] instr);
      b.retire_valid = 1; b.retire_pc = pc; b.retire_instr = instr;
      tick();
      b.retire_valid = 0;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (b.isHalt !== 1'b0) $display("FAIL reset_ishalt: got %h want 0", b.isHalt); else n_pass++;
      n_total++; if (b.ret_val !== 16'h0) $display("FAIL reset_retval: got %h want 0", b.ret_val); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0) $display("FAIL reset_haltpc: got %h want 0", b.halt_pc); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd0) $display("FAIL reset_cause: got %h want 0", b.halt_cause); else n_pass++;
      n_total++; if (b.instret !== 32'd0) $display("FAIL reset_instret: got %h want 0", b.instret); else n_pass++;
   endtask

   task automatic test_halt_instr();
      do_reset();
      b.rf_we = 1; b.rf_waddr = 3; b.rf_wdata = 16'h002A; tick(); b.rf_we = 0;
      retire(16'h0040, 16'hFFFF);
      n_total++; if (b.isHalt !== 1'b0) $display("FAIL hi_early0: got %h want 0", b.isHalt); else n_pass++;
      tick();
      n_total++; if (b.isHalt !== 1'b0) $display("FAIL hi_early1: got %h want 0", b.isHalt); else n_pass++;
      tick();
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL hi_ishalt: got %h want 1", b.isHalt); else n_pass++;
      n_total++; if (b.ret_val !== 16'h002A) $display("FAIL hi_retval: got %h want 002a", b.ret_val); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0040) $display("FAIL hi_haltpc: got %h want 0040", b.halt_pc); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd1) $display("FAIL hi_cause: got %h want 1", b.halt_cause); else n_pass++;
      n_total++; if (b.instret !== 32'd1) $display("FAIL hi_instret: got %h want 1", b.instret); else n_pass++;
   endtask

   task automatic test_drain_write();
      do_reset();
      b.rf_we = 1; b.rf_waddr = 3; b.rf_wdata = 16'h0007;
      retire(16'h0040, 16'hFFFF);
      n_total++; if (b.ret_val !== 16'h0007) $display("FAIL dw_same: got %h want 0007", b.ret_val); else n_pass++;
      b.rf_wdata = 16'h0009; tick(); b.rf_we = 0;
      tick();
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL dw_ishalt: got %h want 1", b.isHalt); else n_pass++;
      n_total++; if (b.ret_val !== 16'h0009) $display("FAIL dw_drain: got %h want 0009", b.ret_val); else n_pass++;
      b.rf_we = 1; b.rf_wdata = 16'h0055; tick(); b.rf_we = 0; tick();
      n_total++; if (b.ret_val !== 16'h0009) $display("FAIL dw_frozen: got %h want 0009", b.ret_val); else n_pass++;
   endtask

   task automatic test_self_loop();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         retire(16'h0010, 16'h1234); tick(); tick();
      end
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL sl_ishalt: got %h want 1", b.isHalt); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd2) $display("FAIL sl_cause: got %h want 2", b.halt_cause); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0010) $display("FAIL sl_haltpc: got %h want 0010", b.halt_pc); else n_pass++;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         retire(16'h0010, 16'h1234); tick();
      end
      retire(16'h0012, 16'h1234); tick(); tick(); tick();
      n_total++; if (b.isHalt !== 1'b0) $display("FAIL sl7_ishalt: got %h want 0", b.isHalt); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd0) $display("FAIL sl7_cause: got %h want 0", b.halt_cause); else n_pass++;
      n_total++; if (b.instret !== 32'd8) $display("FAIL sl7_instret: got %h want 8", b.instret); else n_pass++;
   endtask

   task automatic test_priority_and_disable();
      do_reset();
      for (int i = 0; i < 7; i++) retire(16'h0020, 16'h0000);
      retire(16'h0020, 16'hFFFF); tick(); tick();
      n_total++; if (b.halt_cause !== 2'd1) $display("FAIL pr_cause: got %h want 1", b.halt_cause); else n_pass++;
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL pr_ishalt: got %h want 1", b.isHalt); else n_pass++;
      do_reset();
      for (int i = 0; i < 100; i++) retire(16'h0020, 16'h0000);
      tick(); tick();
      n_total++; if (b2.isHalt !== 1'b0) $display("FAIL nl_ishalt: got %h want 0", b2.isHalt); else n_pass++;
      n_total++; if (b2.instret !== 32'd100) $display("FAIL nl_instret: got %0d want 100", b2.instret); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd2) $display("FAIL nl_ref_cause: got %h want 2", b.halt_cause); else n_pass++;
      n_total++; if (b.instret !== 32'd8) $display("FAIL nl_ref_instret: got %0d want 8", b.instret); else n_pass++;
   endtask

   task automatic test_instret();
      do_reset();
      for (int i = 0; i < 5; i++) retire(16'h0100 + 16'(i), 16'h0000);
      retire(16'h0200, 16'hFFFF);
      n_total++; if (b.instret !== 32'd6) $display("FAIL ir_halt: got %0d want 6", b.instret); else n_pass++;
      retire(16'h0300, 16'hFFFF);
      for (int i = 0; i < 4; i++) retire(16'h0300, 16'h0000);
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL ir_ishalt: got %h want 1", b.isHalt); else n_pass++;
      n_total++; if (b.instret !== 32'd6) $display("FAIL ir_frozen: got %0d want 6", b.instret); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0200) $display("FAIL ir_haltpc: got %h want 0200", b.halt_pc); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      b.rf_we = 1; b.rf_waddr = 3; b.rf_wdata = 16'h1234; tick(); b.rf_we = 0;
      retire(16'h0050, 16'hFFFF);
      tick();
      #2 rst_n = 0;
      #1;
      n_total++; if (b.isHalt !== 1'b0) $display("FAIL ar_ishalt: got %h want 0", b.isHalt); else n_pass++;
      n_total++; if (b.ret_val !== 16'h0) $display("FAIL ar_retval: got %h want 0", b.ret_val); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0) $display("FAIL ar_haltpc: got %h want 0", b.halt_pc); else n_pass++;
      n_total++; if (b.halt_cause !== 2'd0) $display("FAIL ar_cause: got %h want 0", b.halt_cause); else n_pass++;
      n_total++; if (b.instret !== 32'd0) $display("FAIL ar_instret: got %h want 0", b.instret); else n_pass++;
      @(negedge clk); rst_n = 1;
      model_reset();
      retire(16'h0060, 16'hFFFF); tick(); tick();
      n_total++; if (b.isHalt !== 1'b1) $display("FAIL ar_again: got %h want 1", b.isHalt); else n_pass++;
      n_total++; if (b.halt_pc !== 16'h0060) $display("FAIL ar_again_pc: got %h want 0060", b.halt_pc); else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] pc;
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         pc = 16'h0010;
         for (int c = 0; c < 50; c++) begin
            if ($urandom_range(3) == 0) pc = 16'h0010 + 16'($urandom_range(2) * 2);
            b.retire_valid = ($urandom_range(2) != 0);
            b.retire_pc    = pc;
            b.retire_instr = ($urandom_range(30) == 0) ? 16'hFFFF : 16'($urandom_range(16'hFFFE));
            b.rf_we        = $urandom_range(1) == 1;
            b.rf_waddr     = 3'($urandom_range(7));
            b.rf_wdata     = 16'($urandom);
            tick();
            n_total++; if (b.isHalt !== m_is_halt()) $display("FAIL rnd_ishalt ep%0d c%0d: got %h want %h", ep, c, b.isHalt, m_is_halt()); else n_pass++;
            n_total++; if (b.ret_val !== m_ret) $display("FAIL rnd_retval ep%0d c%0d: got %h want %h", ep, c, b.ret_val, m_ret); else n_pass++;
            n_total++; if (b.halt_pc !== m_pc) $display("FAIL rnd_haltpc ep%0d c%0d: got %h want %h", ep, c, b.halt_pc, m_pc); else n_pass++;
            n_total++; if (b.halt_cause !== m_cause) $display("FAIL rnd_cause ep%0d c%0d: got %h want %h", ep, c, b.halt_cause, m_cause); else n_pass++;
            n_total++; if (b.instret !== m_instret) $display("FAIL rnd_instret ep%0d c%0d: got %0d want %0d", ep, c, b.instret, m_instret); else n_pass++;
         end
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_halt_instr();
      test_drain_write();
      test_self_loop();
      test_priority_and_disable();
      test_instret();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
